or1200_keccak_xfer: RTL and testbench
=====================================

Name: or1200_keccak_xfer

Overview:
- Parametrised transfer unit between the or1200 l.cust5 custom-instruction path and an external Keccak-f permutation core.
- Absorb: packs DW-bit operand words, delivered by start/middle/end ops, into LANE_W-bit lanes. Launches the permutation. Stalls the pipeline while the permutation runs.
- Squeeze: serves indexed word reads via the l.cust5 read op (limm = word index).
- Successor to the fixed 7-word, 32-bit load/16-word store flow: configurable width and rate, explicit handshakes, error reporting.

Parameters:
- DW, 32, operand/result word width; LANE_W must be an integer multiple of DW.
- LANE_W, 64, Keccak lane width.
- RATE_LANES, 17, maximum lanes absorbed per block (1..25).
- IDX_W, 6, width of the word index field (cust5 limm).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command presented this cycle.
- cmd_op  in  5  5'b00100 start, 5'b00010 middle, 5'b00001 end, 5'b01000 read; any other value is ignored.
- cmd_data  in  DW  operand word (rA).
- cmd_idx  in  IDX_W  read word index.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready; low drives id/ex freeze.
- rd_valid  out  1  read data valid pulse.
- rd_data  out  DW  read result, to rf_dataw.
- absorb_we  out  1  lane write strobe to core.
- absorb_idx  out  5  lane index.
- absorb_lane  out  LANE_W  assembled lane.
- perm_start  out  1  single-cycle permutation launch.
- perm_done  in  1  permutation complete pulse.
- squeeze_idx  out  5  lane select to core (combinational).
- squeeze_lane  in  LANE_W  selected lane from core (combinational).
- busy  out  1  high in ABSORB, LAUNCH, PERM.
- err  out  1  sticky sequence/overflow error.

Behaviour:
- Reset values: cmd_ready=1, rd_valid=0, rd_data=0, absorb_we=0, absorb_idx=0, absorb_lane=0, perm_start=0, busy=0, err=0, state=IDLE, word counter=0, lane accumulator=0.
- Reset is asynchronous. Asserting it in any state, including PERM, returns to IDLE. A perm_done received outside PERM is ignored.
- WPL = LANE_W/DW words per lane. The word counter holds 0..RATE_LANES*WPL. Words pack little-endian: word k of a lane lands in bits [k*DW +: DW].
- States:
  - IDLE: start → ABSORB. middle/end → err=1, word dropped, state held. read → served.
  - ABSORB: start → counter cleared, err=1 (aborted block), the word becomes word 0. middle → word stored. end → word stored, then LAUNCH. read → err=1, ignored.
  - LAUNCH (1 cycle): flush any partial lane with upper words zero; perm_start=1 on the following cycle; → PERM. cmd_ready=0.
  - PERM: cmd_ready=0; perm_done → READY.
  - READY: behaves as IDLE and remains until start. Reads return permuted data.
- Lane emit: when the word completing a lane is accepted, absorb_we=1 on the next cycle with absorb_idx=counter/WPL and the full lane. The accumulator then clears.
- A partial-lane flush in LAUNCH also produces one absorb_we. perm_start follows the last absorb_we by exactly 1 cycle.
- Overflow: a word accepted with counter=RATE_LANES*WPL is dropped and sets err=1. end still launches.
- Read: accepted only in IDLE/READY. squeeze_idx=cmd_idx/WPL in the same cycle. rd_data = the word cmd_idx%WPL of squeeze_lane, registered. rd_valid pulses 1 cycle later.
- Read range: an index ≥25*WPL returns 0 with rd_valid=1 and sets err=1.
- Back-to-back reads: one per cycle.
- err clears only on reset or on a start accepted in IDLE/READY.

Decomposition:
- Shared package or1200_keccak_pkg:
  - op encodings KC_OP_START/MIDDLE/END/READ.
  - state enum (IDLE, ABSORB, LAUNCH, PERM, READY).
  - constant KECCAK_LANES=25.
- One natural sub-module: or1200_keccak_lane_pack. It is the word-to-lane accumulator with WPL counter, emit strobe and zero-pad flush. The top holds the FSM and the read path.

Test Plan:
- Default params. start 0x1, middle 0x2..0x6, end 0x7:
  - absorb_we at lanes 0=0x00000002_00000001, 1=0x00000004_00000003, 2=0x00000006_00000005.
  - flush lane 3=0x00000000_00000007.
  - perm_start 1 cycle after the last absorb_we; cmd_ready low until perm_done.
- After perm_done with the core model returning lane i = {32'hA0+i, 32'hB0+i}, reads idx 15 down to 0 on consecutive cycles:
  - idx 15 → 0xA7; idx 0 → 0xB0.
  - rd_valid each cycle, 1-cycle latency.
- middle 0x5 in IDLE → err=1, no absorb_we. A following start clears err.
- Overflow: RATE_LANES=2. start + 4 middles + end:
  - 2 absorb_we; extra words dropped; err=1; perm_start still issued.
- rst asserted during PERM:
  - all outputs return to reset values immediately.
  - a later perm_done produces no state change.
- DW=32, LANE_W=128 (WPL=4). 5 words 1..5:
  - lane0=0x4_3_2_1 (32-bit fields).
  - lane1=0x0_0_0_5.
  - read idx 6 returns 0 from lane 1 word 2.

Source files
------------

// File: rtl/or1200_keccak_pkg.sv
// Shared encodings and state type for the or1200 l.cust5 <-> Keccak-f transfer unit.
package or1200_keccak_pkg;

    localparam logic [4:0] KC_OP_START  = 5'b00100;
    localparam logic [4:0] KC_OP_MIDDLE = 5'b00010;
    localparam logic [4:0] KC_OP_END    = 5'b00001;
    localparam logic [4:0] KC_OP_READ   = 5'b01000;

    localparam int KECCAK_LANES = 25;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        LAUNCH,
        PERM,
        READY
    } kc_state_e;

endpackage

// File: rtl/or1200_keccak_lane_pack.sv
// Word-to-lane accumulator: packs DW-bit words little-endian into LANE_W-bit lanes,
// emits each completed lane one cycle after its last word and zero-pads a partial lane on flush.
module or1200_keccak_lane_pack #(
    parameter int DW         = 32,
    parameter int LANE_W     = 64,
    parameter int RATE_LANES = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              word_we,
    input  logic              restart,
    input  logic [DW-1:0]     word_data,
    input  logic              flush,
    output logic              full,
    output logic              partial,
    output logic              absorb_we,
    output logic [4:0]        absorb_idx,
    output logic [LANE_W-1:0] absorb_lane
);

    localparam int WPL       = LANE_W / DW;
    localparam int MAX_WORDS = RATE_LANES * WPL;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);
    localparam int K_W       = (WPL > 1) ? $clog2(WPL) : 1;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_eff;
    logic [K_W-1:0]    k;
    logic [4:0]        lane_no;
    logic [LANE_W-1:0] acc;
    logic [LANE_W-1:0] acc_eff;
    logic [LANE_W-1:0] acc_nxt;
    logic              store;
    logic              lane_done;

    // A restarting word behaves as word 0 of an empty block.
    always_comb begin
        cnt_eff = restart ? '0 : cnt;
        acc_eff = restart ? '0 : acc;
        k       = K_W'(cnt_eff % CNT_W'(WPL));
        lane_no = 5'(cnt_eff / CNT_W'(WPL));
        acc_nxt = acc_eff;
        acc_nxt[k*DW +: DW] = word_data;
        store     = word_we && !full;
        lane_done = store && (k == K_W'(WPL - 1));
    end

    assign full    = (cnt_eff == CNT_W'(MAX_WORDS));
    assign partial = (cnt % CNT_W'(WPL)) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            absorb_we   <= 1'b0;
            absorb_idx  <= '0;
            absorb_lane <= '0;
        end else begin
            absorb_we <= 1'b0;
            if (flush && partial) begin
                absorb_we   <= 1'b1;
                absorb_idx  <= lane_no;
                absorb_lane <= acc;
                acc         <= '0;
            end else if (store) begin
                cnt <= cnt_eff + 1'b1;
                if (lane_done) begin
                    absorb_we   <= 1'b1;
                    absorb_idx  <= lane_no;
                    absorb_lane <= acc_nxt;
                    acc         <= '0;
                end else begin
                    acc <= acc_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/or1200_keccak_xfer.sv
// l.cust5 transfer unit: absorb sequencing, permutation launch/stall and indexed squeeze reads
// between the or1200 pipeline and an external Keccak-f core.
module or1200_keccak_xfer
    import or1200_keccak_pkg::*;
#(
    parameter int DW         = 32,
    parameter int LANE_W     = 64,
    parameter int RATE_LANES = 17,
    parameter int IDX_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [4:0]        cmd_op,
    input  logic [DW-1:0]     cmd_data,
    input  logic [IDX_W-1:0]  cmd_idx,
    output logic              cmd_ready,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic              absorb_we,
    output logic [4:0]        absorb_idx,
    output logic [LANE_W-1:0] absorb_lane,
    output logic              perm_start,
    input  logic              perm_done,
    output logic [4:0]        squeeze_idx,
    input  logic [LANE_W-1:0] squeeze_lane,
    output logic              busy,
    output logic              err
);

    localparam int WPL = LANE_W / DW;
    localparam int K_W = (WPL > 1) ? $clog2(WPL) : 1;

    kc_state_e        state;
    kc_state_e        state_nxt;
    logic             cmd_acc;
    logic             word_we;
    logic             restart;
    logic             flush;
    logic             full;
    logic             partial;
    logic             err_set;
    logic             err_clr;
    logic             rd_go;
    logic             idx_ok;
    logic [K_W-1:0]   word_sel;
    logic [DW-1:0]    rd_word;
    logic             launch_vld_p1;

    assign cmd_ready   = (state != LAUNCH) && (state != PERM);
    assign busy        = (state == ABSORB) || (state == LAUNCH) || (state == PERM);
    assign cmd_acc     = cmd_valid && cmd_ready;
    assign squeeze_idx = 5'(cmd_idx / IDX_W'(WPL));
    assign word_sel    = K_W'(cmd_idx % IDX_W'(WPL));
    assign idx_ok      = 32'(cmd_idx) < 32'(KECCAK_LANES * WPL);
    assign rd_word     = squeeze_lane[word_sel*DW +: DW];

    always_comb begin
        state_nxt = state;
        word_we   = 1'b0;
        restart   = 1'b0;
        flush     = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        rd_go     = 1'b0;
        case (state)
            IDLE, READY: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        KC_OP_START: begin
                            state_nxt = ABSORB;
                            word_we   = 1'b1;
                            restart   = 1'b1;
                            err_clr   = 1'b1;
                        end
                        KC_OP_MIDDLE, KC_OP_END: err_set = 1'b1;
                        KC_OP_READ: begin
                            rd_go   = 1'b1;
                            err_set = !idx_ok;
                        end
                        default: ;
                    endcase
                end
            end
            ABSORB: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        KC_OP_START: begin
                            word_we = 1'b1;
                            restart = 1'b1;
                            err_set = 1'b1;
                        end
                        KC_OP_MIDDLE: word_we = 1'b1;
                        KC_OP_END: begin
                            word_we   = 1'b1;
                            state_nxt = LAUNCH;
                        end
                        KC_OP_READ: err_set = 1'b1;
                        default: ;
                    endcase
                end
            end
            LAUNCH: begin
                flush     = 1'b1;
                state_nxt = PERM;
            end
            PERM: begin
                if (perm_done) state_nxt = READY;
            end
            default: state_nxt = IDLE;
        endcase
        // A word arriving with the rate already filled is dropped.
        if (word_we && full) err_set = 1'b1;
    end

    or1200_keccak_lane_pack #(
        .DW         (DW),
        .LANE_W     (LANE_W),
        .RATE_LANES (RATE_LANES)
    ) u_lane_pack (
        .clk         (clk),
        .rst         (rst),
        .word_we     (word_we),
        .restart     (restart),
        .word_data   (cmd_data),
        .flush       (flush),
        .full        (full),
        .partial     (partial),
        .absorb_we   (absorb_we),
        .absorb_idx  (absorb_idx),
        .absorb_lane (absorb_lane)
    );

    // perm_start trails the last lane write by one cycle, so a flush delays it by one more.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            err           <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            perm_start    <= 1'b0;
            launch_vld_p1 <= 1'b0;
        end else begin
            state         <= state_nxt;
            perm_start    <= launch_vld_p1;
            launch_vld_p1 <= 1'b0;
            if (state == LAUNCH) begin
                if (partial) launch_vld_p1 <= 1'b1;
                else         perm_start    <= 1'b1;
            end
            if (err_clr)      err <= 1'b0;
            else if (err_set) err <= 1'b1;
            rd_valid <= rd_go;
            if (rd_go) rd_data <= idx_ok ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_or1200_keccak_xfer.sv
// Directed bench for or1200_keccak_xfer: default, RATE_LANES=2 and LANE_W=128 instances.
module tb_or1200_keccak_xfer;
    import or1200_keccak_pkg::*;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] d;
    } cmd_t;

    typedef struct {
        logic [5:0]  i;
        logic [31:0] d;
        logic        e;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pd;
    logic [4:0]  op;
    logic [31:0] dat;
    logic [5:0]  idx;
    logic        va, vb, vc;

    logic a_ready, a_rv, a_we, a_ps, a_busy, a_err;
    logic [31:0] a_rd;
    logic [4:0] a_aidx, a_sidx;
    logic [63:0] a_lane, a_sq;

    logic b_ready, b_rv, b_we, b_ps, b_busy, b_err;
    logic [31:0] b_rd;
    logic [4:0] b_aidx, b_sidx;
    logic [63:0] b_lane;

    logic c_ready, c_rv, c_we, c_ps, c_busy, c_err;
    logic [31:0] c_rd;
    logic [4:0] c_aidx, c_sidx;
    logic [127:0] c_lane, c_sq;
    logic [127:0] mem_c [32];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0]   qa_i[$];
    logic [63:0]  qa_l[$];
    logic [4:0]   qb_i[$];
    logic [63:0]  qb_l[$];
    logic [4:0]   qc_i[$];
    logic [127:0] qc_l[$];
    int a_we_cyc = 0, a_ps_cyc = 0, a_ps_n = 0;
    int b_ps_n = 0;
    int c_we_cyc = 0, c_ps_cyc = 0, c_ps_n = 0;

    cmd_t abs_a[7];
    cmd_t seq[$];
    rd_t  rdq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign a_sq = {32'h000000A0 + 32'(a_sidx), 32'h000000B0 + 32'(a_sidx)};
    assign c_sq = mem_c[c_sidx];

    or1200_keccak_xfer dut_a (
        .clk(clk), .rst(rst), .cmd_valid(va), .cmd_op(op), .cmd_data(dat), .cmd_idx(idx),
        .cmd_ready(a_ready), .rd_valid(a_rv), .rd_data(a_rd), .absorb_we(a_we),
        .absorb_idx(a_aidx), .absorb_lane(a_lane), .perm_start(a_ps), .perm_done(pd),
        .squeeze_idx(a_sidx), .squeeze_lane(a_sq), .busy(a_busy), .err(a_err)
    );

    or1200_keccak_xfer #(.RATE_LANES(2)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(vb), .cmd_op(op), .cmd_data(dat), .cmd_idx(idx),
        .cmd_ready(b_ready), .rd_valid(b_rv), .rd_data(b_rd), .absorb_we(b_we),
        .absorb_idx(b_aidx), .absorb_lane(b_lane), .perm_start(b_ps), .perm_done(pd),
        .squeeze_idx(b_sidx), .squeeze_lane(64'h0), .busy(b_busy), .err(b_err)
    );

    or1200_keccak_xfer #(.LANE_W(128)) dut_c (
        .clk(clk), .rst(rst), .cmd_valid(vc), .cmd_op(op), .cmd_data(dat), .cmd_idx(idx),
        .cmd_ready(c_ready), .rd_valid(c_rv), .rd_data(c_rd), .absorb_we(c_we),
        .absorb_idx(c_aidx), .absorb_lane(c_lane), .perm_start(c_ps), .perm_done(pd),
        .squeeze_idx(c_sidx), .squeeze_lane(c_sq), .busy(c_busy), .err(c_err)
    );

    // Lane-write and launch monitors; the C monitor doubles as an identity core model.
    always @(negedge clk) begin
        if (a_we) begin qa_i.push_back(a_aidx); qa_l.push_back(a_lane); a_we_cyc = cyc; end
        if (a_ps) begin a_ps_n = a_ps_n + 1; a_ps_cyc = cyc; end
        if (b_we) begin qb_i.push_back(b_aidx); qb_l.push_back(b_lane); end
        if (b_ps) b_ps_n = b_ps_n + 1;
        if (c_we) begin
            qc_i.push_back(c_aidx); qc_l.push_back(c_lane); c_we_cyc = cyc;
            mem_c[c_aidx] = c_lane;
        end
        if (c_ps) begin c_ps_n = c_ps_n + 1; c_ps_cyc = cyc; end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int inst, input logic [4:0] o, input logic [31:0] d, input logic [5:0] ix);
        va = (inst == 0); vb = (inst == 1); vc = (inst == 2);
        op = o; dat = d; idx = ix;
    endtask

    task automatic send(input int inst, input logic [4:0] o, input logic [31:0] d, input logic [5:0] ix);
        @(negedge clk);
        drive(inst, o, d, ix);
    endtask

    task automatic idle_cmd();
        @(negedge clk);
        va = 1'b0; vb = 1'b0; vc = 1'b0; op = 5'b0; dat = 32'h0; idx = 6'h0;
    endtask

    task automatic rst_pulse();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic run_reads(input int inst);
        @(negedge clk);
        drive(inst, KC_OP_READ, 32'h0, rdq[0].i);
        for (int j = 1; j <= rdq.size(); j++) begin
            @(negedge clk);
            chk($sformatf("rv[%0d]", rdq[j-1].i), (inst == 0) ? a_rv : c_rv, 1'b1);
            chk($sformatf("rd[%0d]", rdq[j-1].i), (inst == 0) ? a_rd : c_rd, rdq[j-1].d);
            chk($sformatf("rerr[%0d]", rdq[j-1].i), (inst == 0) ? a_err : c_err, rdq[j-1].e);
            if (j < rdq.size()) drive(inst, KC_OP_READ, 32'h0, rdq[j].i);
            else begin va = 1'b0; vc = 1'b0; end
        end
        @(negedge clk);
        chk("rv_after", (inst == 0) ? a_rv : c_rv, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1; pd = 1'b0; va = 1'b0; vb = 1'b0; vc = 1'b0;
        op = 5'b0; dat = 32'h0; idx = 6'h0;

        abs_a[0] = '{KC_OP_START, 32'h1};
        for (int k = 1; k <= 5; k++) abs_a[k] = '{KC_OP_MIDDLE, 32'(k + 1)};
        abs_a[6] = '{KC_OP_END, 32'h7};

        repeat (2) @(negedge clk);
        chk("rst_ready", a_ready, 1'b1);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_err", a_err, 1'b0);
        chk("rst_we", a_we, 1'b0);
        chk("rst_ps", a_ps, 1'b0);
        chk("rst_rv", a_rv, 1'b0);
        chk("rst_rd", a_rd, 32'h0);
        chk("rst_lane", {a_aidx, a_lane}, 69'h0);
        rst = 1'b0;

        // Default instance: 7 words, three full lanes plus one flushed lane.
        for (int k = 0; k < 7; k++) begin
            send(0, abs_a[k].op, abs_a[k].d, 6'h0);
            chk($sformatf("a_ready_w%0d", k), a_ready, 1'b1);
        end
        idle_cmd();
        chk("a_ready_launch", a_ready, 1'b0);
        chk("a_busy_launch", a_busy, 1'b1);
        repeat (4) @(negedge clk);
        chk("a_ready_perm", a_ready, 1'b0);
        chk("a_nlanes", 32'(qa_i.size()), 32'd4);
        if (qa_i.size() >= 4) begin
            chk("a_idx0", qa_i[0], 5'd0); chk("a_lane0", qa_l[0], 64'h00000002_00000001);
            chk("a_idx1", qa_i[1], 5'd1); chk("a_lane1", qa_l[1], 64'h00000004_00000003);
            chk("a_idx2", qa_i[2], 5'd2); chk("a_lane2", qa_l[2], 64'h00000006_00000005);
            chk("a_idx3", qa_i[3], 5'd3); chk("a_lane3", qa_l[3], 64'h00000000_00000007);
        end
        chk("a_ps_count", 32'(a_ps_n), 32'd1);
        chk("a_ps_gap", 32'(a_ps_cyc - a_we_cyc), 32'd1);
        @(negedge clk); pd = 1'b1;
        @(negedge clk); pd = 1'b0;
        chk("a_ready_done", a_ready, 1'b1);
        chk("a_busy_done", a_busy, 1'b0);

        for (int k = 15; k >= 0; k--)
            rdq.push_back('{6'(k), (k % 2 == 1) ? 32'(32'hA0 + k / 2) : 32'(32'hB0 + k / 2), 1'b0});
        rdq.push_back('{6'd49, 32'h000000B8, 1'b0});
        rdq.push_back('{6'd50, 32'h0, 1'b1});
        rdq.push_back('{6'd63, 32'h0, 1'b1});
        run_reads(0);
        rdq.delete();

        // Sequencing errors on the default instance.
        rst_pulse();
        base = qa_i.size();
        send(0, KC_OP_MIDDLE, 32'h5, 6'h0);
        idle_cmd();
        chk("idle_mid_err", a_err, 1'b1);
        chk("idle_mid_busy", a_busy, 1'b0);
        send(0, KC_OP_START, 32'h9, 6'h0);
        idle_cmd();
        chk("start_clr_err", a_err, 1'b0);
        chk("start_busy", a_busy, 1'b1);
        send(0, KC_OP_READ, 32'h0, 6'h0);
        idle_cmd();
        chk("absorb_rd_err", a_err, 1'b1);
        chk("absorb_rd_rv", a_rv, 1'b0);
        chk("idle_mid_nowe", 32'(qa_i.size() - base), 32'd0);

        // RATE_LANES=2: overflow drops words but end still launches.
        rst_pulse();
        seq.push_back('{KC_OP_START, 32'h1});
        for (int k = 2; k <= 5; k++) seq.push_back('{KC_OP_MIDDLE, 32'(k)});
        seq.push_back('{KC_OP_END, 32'h6});
        foreach (seq[k]) send(1, seq[k].op, seq[k].d, 6'h0);
        seq.delete();
        idle_cmd();
        repeat (4) @(negedge clk);
        chk("b_nlanes", 32'(qb_i.size()), 32'd2);
        if (qb_i.size() >= 2) begin
            chk("b_lane0", {qb_i[0], qb_l[0]}, {5'd0, 64'h00000002_00000001});
            chk("b_lane1", {qb_i[1], qb_l[1]}, {5'd1, 64'h00000004_00000003});
        end
        chk("b_ovf_err", b_err, 1'b1);
        chk("b_ps_count", 32'(b_ps_n), 32'd1);
        chk("b_busy_perm", b_busy, 1'b1);

        // Asynchronous reset in PERM.
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("b_arst_ready", b_ready, 1'b1);
        chk("b_arst_busy", b_busy, 1'b0);
        chk("b_arst_err", b_err, 1'b0);
        chk("b_arst_outs", {b_we, b_ps, b_rv, b_aidx, b_lane, b_rd}, 104'h0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); pd = 1'b1;
        @(negedge clk); pd = 1'b0;
        chk("b_late_done_busy", b_busy, 1'b0);
        chk("b_late_done_ready", b_ready, 1'b1);
        chk("b_late_done_ps", 32'(b_ps_n), 32'd1);

        // LANE_W=128: four words per lane, second lane flushed.
        seq.push_back('{KC_OP_START, 32'h1});
        for (int k = 2; k <= 4; k++) seq.push_back('{KC_OP_MIDDLE, 32'(k)});
        seq.push_back('{KC_OP_END, 32'h5});
        foreach (seq[k]) send(2, seq[k].op, seq[k].d, 6'h0);
        seq.delete();
        idle_cmd();
        repeat (4) @(negedge clk);
        chk("c_nlanes", 32'(qc_i.size()), 32'd2);
        if (qc_i.size() >= 2) begin
            chk("c_lane0", {qc_i[0], qc_l[0]}, {5'd0, 128'h00000004_00000003_00000002_00000001});
            chk("c_lane1", {qc_i[1], qc_l[1]}, {5'd1, 128'h00000000_00000000_00000000_00000005});
        end
        chk("c_ps_count", 32'(c_ps_n), 32'd1);
        chk("c_ps_gap", 32'(c_ps_cyc - c_we_cyc), 32'd1);
        @(negedge clk); pd = 1'b1;
        @(negedge clk); pd = 1'b0;
        chk("c_ready_done", c_ready, 1'b1);
        @(negedge clk);
        drive(2, KC_OP_READ, 32'h0, 6'd6);
        #1 chk("c_sq_idx6", c_sidx, 5'd1);
        @(negedge clk);
        chk("c_rv6", c_rv, 1'b1);
        chk("c_rd6", c_rd, 32'h0);
        vc = 1'b0;
        rdq.push_back('{6'd4, 32'h5, 1'b0});
        rdq.push_back('{6'd3, 32'h4, 1'b0});
        rdq.push_back('{6'd0, 32'h1, 1'b0});
        run_reads(2);
        rdq.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
